// File: rtl/dso100fb_timing_gen.sv
// Panel timing generator: horizontal/vertical porch FSMs, active-area position and
// per-window enables. All outputs come from one register stage so they stay aligned.
module dso100fb_timing_gen #(
  parameter int CW   = 12,
  parameter int NWIN = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 en_i,
  input  logic [CW-1:0]        hact_i,
  input  logic [CW-1:0]        hfp_i,
  input  logic [CW-1:0]        hsp_i,
  input  logic [CW-1:0]        hbp_i,
  input  logic [CW-1:0]        vact_i,
  input  logic [CW-1:0]        vfp_i,
  input  logic [CW-1:0]        vsp_i,
  input  logic [CW-1:0]        vbp_i,
  input  logic [NWIN*CW-1:0]   win_x_i,
  input  logic [NWIN*CW-1:0]   win_w_i,
  input  logic [NWIN*CW-1:0]   win_y_i,
  input  logic [NWIN*CW-1:0]   win_h_i,
  input  logic                 hsync_pol_i,
  input  logic                 vsync_pol_i,
  input  logic                 de_pol_i,
  output logic                 vid_de_o,
  output logic                 vid_hsync_o,
  output logic                 vid_vsync_o,
  output logic                 video_fetch_o,
  output logic [NWIN-1:0]      win_en_o,
  output logic [CW-1:0]        pos_x_o,
  output logic [CW-1:0]        pos_y_o,
  output logic                 frame_o,
  output logic                 line_o,
  output logic                 cfg_err_o
);

  // phase    | meaning (shared by the horizontal and vertical FSMs)
  // ST_IDLE  | stopped, outputs inactive
  // ST_FP    | front porch
  // ST_SP    | sync pulse
  // ST_BP    | back porch
  // ST_ACT   | active pixels / lines
  typedef enum logic [2:0] {ST_IDLE, ST_FP, ST_SP, ST_BP, ST_ACT} phase_e;

  typedef struct packed {
    logic [CW-1:0]      hact, hfp, hsp, hbp;
    logic [CW-1:0]      vact, vfp, vsp, vbp;
    logic [NWIN*CW-1:0] wx, ww, wy, wh;
    logic               hpol, vpol, dpol;
  } cfg_t;

  function automatic phase_e next_phase(phase_e p, logic [CW-1:0] fp, logic [CW-1:0] sp,
                                        logic [CW-1:0] bp);
    phase_e n;
    n = ST_ACT;
    if ((p == ST_IDLE || p == ST_ACT) && fp != '0)                      n = ST_FP;
    else if ((p == ST_IDLE || p == ST_ACT || p == ST_FP) && sp != '0)   n = ST_SP;
    else if (p != ST_BP && bp != '0)                                    n = ST_BP;
    return n;
  endfunction

  function automatic logic [CW-1:0] phase_len(phase_e p, logic [CW-1:0] fp, logic [CW-1:0] sp,
                                              logic [CW-1:0] bp, logic [CW-1:0] act);
    logic [CW-1:0] l;
    case (p)
      ST_FP:   l = fp;
      ST_SP:   l = sp;
      ST_BP:   l = bp;
      ST_ACT:  l = act;
      default: l = '0;
    endcase
    return l;
  endfunction

  function automatic logic cfg_ok(cfg_t c);
    logic [CW+2:0] ht, vt;
    ht = {3'b0, c.hfp} + {3'b0, c.hsp} + {3'b0, c.hbp} + {3'b0, c.hact};
    vt = {3'b0, c.vfp} + {3'b0, c.vsp} + {3'b0, c.vbp} + {3'b0, c.vact};
    return (c.hact != '0) && (c.vact != '0) && !ht[CW+2] && !vt[CW+2];
  endfunction

  cfg_t          cfg_in, sh_q, sh_d;
  phase_e        hs_q, hs_d, vs_q, vs_d, hn, vn;
  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, x_q, x_d, y_q, y_d;
  logic          line_q, line_d, frame_q, frame_d;
  logic          blocked_q, blocked_d, err_q, err_d, load, de;
  logic [NWIN-1:0] win_d;

  logic          vid_de_q, vid_hsync_q, vid_vsync_q, fetch_q, frame_out_q, line_out_q, cfg_err_q;
  logic [NWIN-1:0] win_en_q;
  logic [CW-1:0] pos_x_q, pos_y_q;

  always_comb begin
    cfg_in = '{hact: hact_i, hfp: hfp_i, hsp: hsp_i, hbp: hbp_i,
               vact: vact_i, vfp: vfp_i, vsp: vsp_i, vbp: vbp_i,
               wx: win_x_i, ww: win_w_i, wy: win_y_i, wh: win_h_i,
               hpol: hsync_pol_i, vpol: vsync_pol_i, dpol: de_pol_i};
  end

  always_comb begin
    hs_d      = hs_q;
    vs_d      = vs_q;
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    x_d       = x_q;
    y_d       = y_q;
    line_d    = 1'b0;
    frame_d   = 1'b0;
    blocked_d = blocked_q;
    err_d     = err_q;
    sh_d      = sh_q;
    load      = 1'b0;
    hn        = ST_IDLE;
    vn        = ST_IDLE;
    if (!en_i) begin
      hs_d      = ST_IDLE;
      vs_d      = ST_IDLE;
      hcnt_d    = '0;
      vcnt_d    = '0;
      x_d       = '0;
      y_d       = '0;
      blocked_d = 1'b0;
    end else if (hs_q == ST_IDLE) begin
      load = !blocked_q;
    end else if (hs_q == ST_ACT && hcnt_q == '0 && vs_q == ST_ACT && vcnt_q == '0) begin
      load = 1'b1;
    end else if (hs_q == ST_ACT && hcnt_q == '0) begin
      hn     = next_phase(ST_IDLE, sh_q.hfp, sh_q.hsp, sh_q.hbp);
      hs_d   = hn;
      hcnt_d = phase_len(hn, sh_q.hfp, sh_q.hsp, sh_q.hbp, sh_q.hact) - 1'b1;
      x_d    = '0;
      line_d = 1'b1;
      if (vcnt_q == '0) begin
        vn     = next_phase(vs_q, sh_q.vfp, sh_q.vsp, sh_q.vbp);
        vs_d   = vn;
        vcnt_d = phase_len(vn, sh_q.vfp, sh_q.vsp, sh_q.vbp, sh_q.vact) - 1'b1;
        y_d    = '0;
      end else begin
        vcnt_d = vcnt_q - 1'b1;
        y_d    = (vs_q == ST_ACT) ? y_q + 1'b1 : '0;
      end
    end else if (hcnt_q == '0) begin
      hn     = next_phase(hs_q, sh_q.hfp, sh_q.hsp, sh_q.hbp);
      hs_d   = hn;
      hcnt_d = phase_len(hn, sh_q.hfp, sh_q.hsp, sh_q.hbp, sh_q.hact) - 1'b1;
      x_d    = '0;
    end else begin
      hcnt_d = hcnt_q - 1'b1;
      x_d    = (hs_q == ST_ACT) ? x_q + 1'b1 : '0;
    end

    // Frame start: the new frame is laid out from the live inputs being captured now.
    if (load) begin
      sh_d  = cfg_in;
      err_d = !cfg_ok(cfg_in);
      x_d   = '0;
      y_d   = '0;
      if (cfg_ok(cfg_in)) begin
        hn      = next_phase(ST_IDLE, cfg_in.hfp, cfg_in.hsp, cfg_in.hbp);
        vn      = next_phase(ST_IDLE, cfg_in.vfp, cfg_in.vsp, cfg_in.vbp);
        hs_d    = hn;
        vs_d    = vn;
        hcnt_d  = phase_len(hn, cfg_in.hfp, cfg_in.hsp, cfg_in.hbp, cfg_in.hact) - 1'b1;
        vcnt_d  = phase_len(vn, cfg_in.vfp, cfg_in.vsp, cfg_in.vbp, cfg_in.vact) - 1'b1;
        line_d  = 1'b1;
        frame_d = 1'b1;
      end else begin
        hs_d      = ST_IDLE;
        vs_d      = ST_IDLE;
        hcnt_d    = '0;
        vcnt_d    = '0;
        blocked_d = 1'b1;
      end
    end
  end

  assign de = (hs_q == ST_ACT) && (vs_q == ST_ACT);

  // Window bounds are compared in CW+1 bits so a window running past 2^CW does not wrap.
  always_comb begin
    win_d = '0;
    for (int i = 0; i < NWIN; i++) begin
      win_d[i] = de
        && ({1'b0, x_q} >= {1'b0, sh_q.wx[i*CW +: CW]})
        && ({1'b0, x_q} <  ({1'b0, sh_q.wx[i*CW +: CW]} + {1'b0, sh_q.ww[i*CW +: CW]}))
        && ({1'b0, y_q} >= {1'b0, sh_q.wy[i*CW +: CW]})
        && ({1'b0, y_q} <  ({1'b0, sh_q.wy[i*CW +: CW]} + {1'b0, sh_q.wh[i*CW +: CW]}));
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hs_q      <= ST_IDLE;
      vs_q      <= ST_IDLE;
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      line_q    <= 1'b0;
      frame_q   <= 1'b0;
      blocked_q <= 1'b0;
      err_q     <= 1'b0;
      sh_q      <= '0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      x_q       <= x_d;
      y_q       <= y_d;
      line_q    <= line_d;
      frame_q   <= frame_d;
      blocked_q <= blocked_d;
      err_q     <= err_d;
      sh_q      <= sh_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vid_de_q    <= 1'b0;
      vid_hsync_q <= 1'b0;
      vid_vsync_q <= 1'b0;
      fetch_q     <= 1'b0;
      win_en_q    <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      frame_out_q <= 1'b0;
      line_out_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      vid_de_q    <= de ^ sh_q.dpol;
      vid_hsync_q <= (hs_q == ST_SP) ^ sh_q.hpol;
      vid_vsync_q <= (vs_q == ST_SP) ^ sh_q.vpol;
      fetch_q     <= de;
      win_en_q    <= win_d;
      pos_x_q     <= x_q;
      pos_y_q     <= y_q;
      frame_out_q <= frame_q;
      line_out_q  <= line_q;
      cfg_err_q   <= err_q;
    end
  end

  assign vid_de_o      = vid_de_q;
  assign vid_hsync_o   = vid_hsync_q;
  assign vid_vsync_o   = vid_vsync_q;
  assign video_fetch_o = fetch_q;
  assign win_en_o      = win_en_q;
  assign pos_x_o       = pos_x_q;
  assign pos_y_o       = pos_y_q;
  assign frame_o       = frame_out_q;
  assign line_o        = line_out_q;
  assign cfg_err_o     = cfg_err_q;

endmodule

// File: tb/tb_dso100fb_timing_gen.sv
// Bench for dso100fb_timing_gen: frame-index arithmetic model checked every cycle,
// plus literal expectations for the directed timing scenarios.
module tb_dso100fb_timing_gen;
  localparam int CW   = 12;
  localparam int NWIN = 2;
  localparam int VW   = 4 + NWIN + 2*CW + 3;

  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [CW-1:0] hact, hfp, hsp, hbp, vact, vfp, vsp, vbp;
  logic [NWIN*CW-1:0] win_x, win_w, win_y, win_h;
  logic hpol, vpol, dpol;
  logic vid_de_o, vid_hsync_o, vid_vsync_o, video_fetch_o, frame_o, line_o, cfg_err_o;
  logic [NWIN-1:0] win_en_o;
  logic [CW-1:0] pos_x_o, pos_y_o;

  int checks = 0, errors = 0;

  dso100fb_timing_gen #(.CW(CW), .NWIN(NWIN)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en),
    .hact_i(hact), .hfp_i(hfp), .hsp_i(hsp), .hbp_i(hbp),
    .vact_i(vact), .vfp_i(vfp), .vsp_i(vsp), .vbp_i(vbp),
    .win_x_i(win_x), .win_w_i(win_w), .win_y_i(win_y), .win_h_i(win_h),
    .hsync_pol_i(hpol), .vsync_pol_i(vpol), .de_pol_i(dpol),
    .vid_de_o(vid_de_o), .vid_hsync_o(vid_hsync_o), .vid_vsync_o(vid_vsync_o),
    .video_fetch_o(video_fetch_o), .win_en_o(win_en_o),
    .pos_x_o(pos_x_o), .pos_y_o(pos_y_o),
    .frame_o(frame_o), .line_o(line_o), .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  // Model: a running frame is just a cycle index into an htot x vtot raster.
  bit m_run, m_blk, m_err;
  int m_t;
  int s_hact, s_hfp, s_hsp, s_hbp, s_vact, s_vfp, s_vsp, s_vbp;
  int swx[NWIN], sww[NWIN], swy[NWIN], swh[NWIN];
  bit s_hpol, s_vpol, s_dpol;
  logic [VW-1:0] exp_v;
  logic [VW-1:0] dut_v;

  assign dut_v = {vid_de_o, vid_hsync_o, vid_vsync_o, video_fetch_o, win_en_o,
                  pos_x_o, pos_y_o, frame_o, line_o, cfg_err_o};

  task automatic capture();
    s_hact = int'(hact); s_hfp = int'(hfp); s_hsp = int'(hsp); s_hbp = int'(hbp);
    s_vact = int'(vact); s_vfp = int'(vfp); s_vsp = int'(vsp); s_vbp = int'(vbp);
    for (int i = 0; i < NWIN; i++) begin
      swx[i] = int'(win_x[i*CW +: CW]); sww[i] = int'(win_w[i*CW +: CW]);
      swy[i] = int'(win_y[i*CW +: CW]); swh[i] = int'(win_h[i*CW +: CW]);
    end
    s_hpol = hpol; s_vpol = vpol; s_dpol = dpol;
    m_err = !(s_hact != 0 && s_vact != 0);
  endtask

  function automatic logic [VW-1:0] view();
    int htot, hp, ln, hoff, voff, x, y;
    logic de, hs, vs, fr, li;
    logic [NWIN-1:0] w;
    de = 0; hs = 0; vs = 0; fr = 0; li = 0; x = 0; y = 0; w = '0;
    if (m_run) begin
      htot = s_hfp + s_hsp + s_hbp + s_hact;
      hp = m_t % htot;
      ln = m_t / htot;
      hoff = s_hfp + s_hsp + s_hbp;
      voff = s_vfp + s_vsp + s_vbp;
      hs = (hp >= s_hfp) && (hp < s_hfp + s_hsp);
      vs = (ln >= s_vfp) && (ln < s_vfp + s_vsp);
      if (hp >= hoff) x = hp - hoff;
      if (ln >= voff) y = ln - voff;
      de = (hp >= hoff) && (ln >= voff);
      fr = (m_t == 0);
      li = (hp == 0);
      for (int i = 0; i < NWIN; i++)
        w[i] = de && x >= swx[i] && x < swx[i] + sww[i] && y >= swy[i] && y < swy[i] + swh[i];
    end
    return {de ^ s_dpol, hs ^ s_hpol, vs ^ s_vpol, de, w, CW'(x), CW'(y), fr, li, m_err};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_blk = 0; m_err = 0; m_t = 0;
      s_hact = 0; s_hfp = 0; s_hsp = 0; s_hbp = 0; s_vact = 0; s_vfp = 0; s_vsp = 0; s_vbp = 0;
      for (int i = 0; i < NWIN; i++) begin swx[i] = 0; sww[i] = 0; swy[i] = 0; swh[i] = 0; end
      s_hpol = 0; s_vpol = 0; s_dpol = 0;
      exp_v = '0;
    end else begin
      exp_v = view();
      if (!en) begin
        m_run = 0; m_blk = 0;
      end else if (!m_run) begin
        if (!m_blk) begin
          capture();
          if (!m_err) begin m_run = 1; m_t = 0; end
          else m_blk = 1;
        end
      end else begin
        m_t++;
        if (m_t == (s_hfp + s_hsp + s_hbp + s_hact) * (s_vfp + s_vsp + s_vbp + s_vact)) begin
          capture();
          if (!m_err) m_t = 0;
          else begin m_run = 0; m_blk = 1; end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dut_v !== exp_v) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t dut={de,hs,vs,fetch,win,x,y,fr,ln,err}=%h model=%h",
                 $time, dut_v, exp_v);
      end
    end
  end

  task automatic check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic set_cfg(int ha, int hf, int hs, int hb, int va, int vf, int vs, int vb);
    hact = CW'(ha); hfp = CW'(hf); hsp = CW'(hs); hbp = CW'(hb);
    vact = CW'(va); vfp = CW'(vf); vsp = CW'(vs); vbp = CW'(vb);
  endtask

  task automatic set_win(int i, int x, int w, int y, int h);
    win_x[i*CW +: CW] = CW'(x); win_w[i*CW +: CW] = CW'(w);
    win_y[i*CW +: CW] = CW'(y); win_h[i*CW +: CW] = CW'(h);
  endtask

  task automatic wait_frame(output bit ok);
    ok = 0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (frame_o) begin ok = 1; break; end
    end
    if (!ok) check("frame_timeout", 0, 1);
  endtask

  task automatic measure(output int per, output int dec, output int hsc, output int w0, output int w1);
    bit ok;
    per = 0; dec = 0; hsc = 0; w0 = 0; w1 = 0;
    wait_frame(ok);
    if (ok) begin
      do begin
        per++; dec += int'(video_fetch_o); hsc += int'(vid_hsync_o);
        w0 += int'(win_en_o[0]); w1 += int'(win_en_o[1]);
        @(negedge clk);
      end while (!frame_o && per < 2000);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int per, dec, hsc, w0, w1, n;
    hpol = 0; vpol = 0; dpol = 0;
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
    win_x = '0; win_w = '0; win_y = '0; win_h = '0;
    set_win(0, 1, 2, 1, 2);
    set_win(1, 3, 4, 0, 5);
    #23;
    check("reset_flags", int'({vid_de_o, vid_hsync_o, vid_vsync_o, video_fetch_o, win_en_o,
                               frame_o, line_o, cfg_err_o}), 0);
    check("reset_pos", int'({pos_x_o, pos_y_o}), 0);
    @(negedge clk); rst_n = 1;
    repeat (4) @(negedge clk);
    check("idle_until_en", int'(video_fetch_o | frame_o | line_o), 0);

    en = 1;
    measure(per, dec, hsc, w0, w1);
    check("base_frame_period", per, 48);
    check("base_de_per_frame", dec, 12);
    check("base_hsync_per_frame", hsc, 12);
    check("win0_cycles", w0, 4);
    check("win1_clipped_cycles", w1, 3);

    set_cfg(4, 1, 0, 1, 3, 1, 1, 1);
    measure(per, dec, hsc, w0, w1);
    check("hsp0_frame_period", per, 36);
    check("hsp0_no_hsync", hsc, 0);
    check("hsp0_de", dec, 12);

    set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
    measure(per, dec, hsc, w0, w1);
    check("restore_period", per, 48);
    wait_frame(per[0]);
    repeat (10) @(negedge clk);
    set_cfg(6, 1, 2, 1, 3, 1, 1, 1);
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_o && n < 2000);
    check("midframe_change_rest", n, 38);
    measure(per, dec, hsc, w0, w1);
    check("hact6_period", per, 60);
    check("hact6_de", dec, 18);

    for (n = 0; n < 200; n++) begin @(negedge clk); if (video_fetch_o) break; end
    check("found_active", int'(video_fetch_o), 1);
    en = 0;
    @(negedge clk); @(negedge clk);
    check("drop_en_de", int'(video_fetch_o), 0);
    check("drop_en_posx", int'(pos_x_o), 0);
    repeat (3) @(negedge clk);
    en = 1;
    @(negedge clk); @(negedge clk);
    check("restart_frame_line", int'({frame_o, line_o}), 3);

    en = 0;
    set_cfg(0, 1, 2, 1, 3, 1, 1, 1);
    @(negedge clk); @(negedge clk);
    en = 1;
    repeat (3) @(negedge clk);
    check("hact0_cfg_err", int'(cfg_err_o), 1);
    check("hact0_idle", int'(video_fetch_o | line_o), 0);
    set_cfg(4, 1, 2, 1, 3, 1, 1, 1);
    en = 0;
    @(negedge clk);
    en = 1;
    measure(per, dec, hsc, w0, w1);
    check("recover_period", per, 48);
    check("recover_cfg_err", int'(cfg_err_o), 0);

    for (int it = 0; it < 40; it++) begin
      set_cfg(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6),
              $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
      for (int i = 0; i < NWIN; i++)
        set_win(i, $urandom_range(0, 6), $urandom_range(0, 5), $urandom_range(0, 4), $urandom_range(0, 4));
      hpol = 1'($urandom); vpol = 1'($urandom); dpol = 1'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        en = 0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        en = 1;
      end
      repeat ($urandom_range(10, 150)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dso100fb_timing_gen.md
DSO100FB_TIMING_GEN -- requirements
Module: dso100fb_timing_gen

Interface
REQ-001 Parameter CW, default 12, SHALL set the width of every timing field, position counter and window coordinate.
REQ-002 Parameter NWIN, default 2, SHALL set the number of independent rectangular overlay windows (1..8).
REQ-003 CLK  in  1  video pixel clock; the only clock in the block.
REQ-004 RST_N  in  1  reset, asynchronous and active-low.
REQ-005 EN  in  1  run enable; already synchronous to CLK.
REQ-006 HACT, HFP, HSP, HBP  in  CW each  horizontal active, front porch, sync, back porch lengths in pixels.
REQ-007 VACT, VFP, VSP, VBP  in  CW each  vertical equivalents in lines.
REQ-008 WIN_X, WIN_W, WIN_Y, WIN_H  in  NWIN*CW each  packed window origin and size; window i occupies slice [i*CW +: CW].
REQ-009 HSYNC_POL, VSYNC_POL, DE_POL  in  1 each  1 = invert the corresponding output.
REQ-010 VID_DE, VID_HSYNC, VID_VSYNC  out  1 each  registered panel timing, polarity applied.
REQ-011 VIDEO_FETCH  out  1  registered, unpolarised data-enable.
REQ-012 WIN_EN  out  NWIN  registered per-window enable, bit i = window i.
REQ-013 POS_X, POS_Y  out  CW each  registered active-area pixel and line index.
REQ-014 FRAME, LINE  out  1 each  single-cycle start-of-frame and start-of-line pulses.
REQ-015 CFG_ERR  out  1  registered; high while shadowed config is unusable.

Function
REQ-016 All timing, window and polarity inputs SHALL be captured into shadow registers on the IDLE->run transition and on every FRAME cycle; no other cycle SHALL change the shadows.
REQ-017 Horizontal FSM states SHALL be IDLE, HFP, HSP, HBP, HACT, visited in that order and wrapping HACT->HFP.
REQ-018 Each horizontal state SHALL last exactly its programmed count of CLK cycles; a state programmed 0 SHALL be skipped with no idle cycle.
REQ-019 Vertical FSM states SHALL be IDLE, VFP, VSP, VBP, VACT with the same ordering and skip rule, advancing one line per LINE pulse.
REQ-020 LINE SHALL pulse on the first cycle of HFP (or the first non-skipped state of the line); FRAME SHALL pulse on the LINE cycle that starts the first line of a frame.
REQ-021 Internal hsync SHALL be high throughout HSP; internal vsync high for every cycle of lines in VSP, changing only on LINE cycles.
REQ-022 Internal de SHALL equal (hstate==HACT && vstate==VACT).
REQ-023 POS_X SHALL count 0..HACT-1 across HACT cycles; POS_Y SHALL count 0..VACT-1 across VACT lines; both hold 0 outside their active region.
REQ-024 WIN_EN[i] SHALL be de && WIN_X<=x<WIN_X+WIN_W && WIN_Y<=y<WIN_Y+WIN_H, sums computed in CW+1 bits so windows extending past 2^CW do not wrap; zero-size window SHALL never assert.
REQ-025 All registered outputs SHALL share one cycle of latency from internal state so DE, syncs, WIN_EN and POS_X/Y stay aligned.
REQ-026 VID_DE = de^DE_POL, VID_HSYNC = hsync^HSYNC_POL, VID_VSYNC = vsync^VSYNC_POL.
REQ-027 CFG_ERR SHALL assert, and the block stay in IDLE, when shadowed HACT==0, VACT==0, or horizontal or vertical total overflows CW+2 bits.
REQ-028 EN deasserted in any state SHALL force both FSMs to IDLE on the next edge; frame abandoned mid-line, no FRAME/LINE pulse emitted.
REQ-029 EN reasserted SHALL restart from the first cycle of HFP/VFP with FRAME and LINE pulsing on that cycle.
REQ-030 In IDLE, de, hsync, vsync, WIN_EN and POS_X/Y SHALL be inactive/zero, polarity still applied to VID_*.

Reset
REQ-031 On RST_N low, all FSMs SHALL enter IDLE and every output and shadow register SHALL be 0 asynchronously.
REQ-032 After RST_N release, the block SHALL stay IDLE until EN is sampled high.

Verification
REQ-033 HACT=4,HFP=1,HSP=2,HBP=1,VACT=3,VFP=1,VSP=1,VBP=1, EN high -> line period 8 cycles, frame 6 lines, VID_DE high 4 cycles on lines 4..6, FRAME every 48 cycles.
REQ-034 Same config, HSP=0 -> HSYNC never asserts, line period 6 cycles, no gap cycles.
REQ-035 NWIN=2, win0 (1,1,2,2), win1 (3,0,4,5) -> WIN_EN[0] at x=1..2,y=1..2; WIN_EN[1] only x=3, y=0..2 (clipped).
REQ-036 Change HACT 4->6 mid-frame -> current frame unchanged, new width from the first line after next FRAME.
REQ-037 Drop EN mid-HACT -> next cycle de=0, POS=0; re-enable -> FRAME and LINE pulse on restart cycle.
REQ-038 HACT=0 on enable -> CFG_ERR=1, outputs idle; set HACT=4 and toggle EN -> normal timing, CFG_ERR=0.
